mgr_noc_locl_arb: RTL and testbench

- Round-robin, packet-atomic arbiter that shares the manager's local-to-NoC port (locl__noc__dp_*) among NUM_REQ local packet sources, e.g. the WU decoder response path, the result/return path and the config/status path.
- Sits between those sources and the manager NoC controller.
- Holds a grant from SOM through EOM so packets are never interleaved.
- Registers its output through a 2-entry FIFO to break the timing path to the NoC.

---
 rtl/mgr_noc_locl_arb_if.sv | 45 ++++
 rtl/mgr_noc_locl_arb.sv | 184 ++++++++++++++++++
 tb/tb_mgr_noc_locl_arb.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgr_noc_locl_arb_if.sv
// Local-packet bus between the requesters, the arbiter and the manager NoC controller.
// The arbiter uses the slave view; the sources and NoC side use the master view.
interface mgr_noc_locl_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TYPE_W  = 2,
  parameter int PTYPE_W = 3,
  parameter int DEST_W  = 2,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]         req__arb__valid;
  logic [2*NUM_REQ-1:0]       req__arb__cntl;
  logic [TYPE_W*NUM_REQ-1:0]  req__arb__type;
  logic [PTYPE_W*NUM_REQ-1:0] req__arb__ptype;
  logic [DEST_W*NUM_REQ-1:0]  req__arb__desttype;
  logic [NUM_REQ-1:0]         req__arb__pvalid;
  logic [DATA_W*NUM_REQ-1:0]  req__arb__data;
  logic [NUM_REQ-1:0]         arb__req__ready;

  logic                       locl__noc__dp_valid;
  logic [1:0]                 locl__noc__dp_cntl;
  logic [TYPE_W-1:0]          locl__noc__dp_type;
  logic [PTYPE_W-1:0]         locl__noc__dp_ptype;
  logic [DEST_W-1:0]          locl__noc__dp_desttype;
  logic                       locl__noc__dp_pvalid;
  logic [DATA_W-1:0]          locl__noc__dp_data;
  logic                       noc__locl__dp_ready;

  modport slave (
    input  req__arb__valid, req__arb__cntl, req__arb__type, req__arb__ptype,
    input  req__arb__desttype, req__arb__pvalid, req__arb__data,
    output arb__req__ready,
    output locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type, locl__noc__dp_ptype,
    output locl__noc__dp_desttype, locl__noc__dp_pvalid, locl__noc__dp_data,
    input  noc__locl__dp_ready
  );

  modport master (
    output req__arb__valid, req__arb__cntl, req__arb__type, req__arb__ptype,
    output req__arb__desttype, req__arb__pvalid, req__arb__data,
    input  arb__req__ready,
    input  locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type, locl__noc__dp_ptype,
    input  locl__noc__dp_desttype, locl__noc__dp_pvalid, locl__noc__dp_data,
    output noc__locl__dp_ready
  );
endinterface

// File: rtl/mgr_noc_locl_arb.sv
// Round-robin, packet-atomic arbiter for the manager local-to-NoC port, output through a 2-entry FIFO.
// Optional locked-packet idle watchdog: define MGR_NOC_LOCL_ARB_WATCHDOG_EN.
module mgr_noc_locl_arb #(
  parameter int NUM_REQ  = 4,
  parameter int TYPE_W   = 2,
  parameter int PTYPE_W  = 3,
  parameter int DEST_W   = 2,
  parameter int DATA_W   = 64,
  parameter int WDOG_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  mgr_noc_locl_arb_if.slave bus,
  output logic              arb__busy,
  output logic [2:0]        arb__owner,
  output logic              arb__err
);
  localparam int BEAT_W = 2 + TYPE_W + PTYPE_W + DEST_W + 1 + DATA_W;
  localparam logic [1:0] CNTL_SOM = 2'b01;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         rr_ptr_reg, rr_ptr_next;
  logic [2:0]         owner_reg, owner_next;
  logic [2:0]         winner, sel;
  logic [3:0]         arb_pos;
  logic               found, sel_valid, space, push, pop, wdog_abort;
  logic [7:0]         valid_pad;
  logic [BEAT_W-1:0]  beat_pad [8];
  logic [BEAT_W-1:0]  beat_sel, head_reg, tail_reg;
  logic [1:0]         sel_cntl;
  logic [1:0]         count_reg;
  logic [NUM_REQ-1:0] ready_vec;

  function automatic logic [2:0] rr_inc(input logic [2:0] x);
    return (x == 3'(NUM_REQ - 1)) ? 3'd0 : x + 3'd1;
  endfunction

  // Requester lanes padded to 8 so a 3-bit index is always in range.
  assign valid_pad = 8'(bus.req__arb__valid);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_beat
      if (gi < NUM_REQ) begin : g_req
        assign beat_pad[gi] = {bus.req__arb__cntl[2*gi +: 2],
                               bus.req__arb__type[TYPE_W*gi +: TYPE_W],
                               bus.req__arb__ptype[PTYPE_W*gi +: PTYPE_W],
                               bus.req__arb__desttype[DEST_W*gi +: DEST_W],
                               bus.req__arb__pvalid[gi],
                               bus.req__arb__data[DATA_W*gi +: DATA_W]};
      end else begin : g_none
        assign beat_pad[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    arb_pos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_pos = 4'(rr_ptr_reg) + 4'(i);
      if (arb_pos >= 4'(NUM_REQ)) arb_pos = arb_pos - 4'(NUM_REQ);
      if (!found && valid_pad[arb_pos[2:0]]) begin
        winner = arb_pos[2:0];
        found  = 1'b1;
      end
    end
  end

  assign sel       = (state_reg == LOCKED) ? owner_reg : winner;
  assign sel_valid = (state_reg == LOCKED) ? valid_pad[owner_reg] : found;
  assign space     = (count_reg != 2'd2);
  assign push      = space & sel_valid;
  assign pop       = (count_reg != 2'd0) & bus.noc__locl__dp_ready;
  assign beat_sel  = beat_pad[sel];
  assign sel_cntl  = beat_sel[BEAT_W-1 -: 2];

  // Ready is masked during reset so a requester mid-packet cannot see a stray grant.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ready_vec[gi] = reset_poweron_n & space & (sel == 3'(gi)) &
                             ((state_reg == LOCKED) | found);
    end
  endgenerate
  assign bus.arb__req__ready = ready_vec;

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      if (push && (count_reg == 2'd0 || (count_reg == 2'd1 && pop)))
        head_reg <= beat_sel;
      else if (pop && count_reg == 2'd2)
        head_reg <= tail_reg;
      if (push && count_reg == 2'd1 && !pop)
        tail_reg <= beat_sel;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign bus.locl__noc__dp_valid = (count_reg != 2'd0);
  assign {bus.locl__noc__dp_cntl, bus.locl__noc__dp_type, bus.locl__noc__dp_ptype,
          bus.locl__noc__dp_desttype, bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data} = head_reg;

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 3'd0;
      owner_reg  <= 3'd0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    case (state_reg)
      IDLE: begin
        if (push) begin
          owner_next = winner;
          if (sel_cntl == CNTL_SOM) state_next  = LOCKED;
          else                      rr_ptr_next = rr_inc(winner);
        end
      end
      LOCKED: begin
        // cntl[1] marks EOM and SOM_EOM; a watchdog abort leaves the packet unterminated.
        if ((push && sel_cntl[1]) || wdog_abort) begin
          state_next  = IDLE;
          rr_ptr_next = rr_inc(owner_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign arb__busy  = (state_reg == LOCKED);
  assign arb__owner = owner_reg;

`ifdef MGR_NOC_LOCL_ARB_WATCHDOG_EN
  logic [7:0] wdog_cnt_reg, wdog_cnt_next;
  logic       err_reg;

  always_comb begin
    wdog_cnt_next = 8'd0;
    wdog_abort    = 1'b0;
    if (state_reg == LOCKED && !push) begin
      wdog_cnt_next = wdog_cnt_reg;
      // Only owner gaps count; a stall from a full FIFO is not the owner's fault.
      if (!valid_pad[owner_reg]) begin
        if (wdog_cnt_reg + 8'd1 == 8'(WDOG_CYC)) begin
          wdog_abort    = 1'b1;
          wdog_cnt_next = 8'd0;
        end else begin
          wdog_cnt_next = wdog_cnt_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      wdog_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      err_reg      <= err_reg | wdog_abort;
    end
  end

  assign arb__err = err_reg;
`else
  assign wdog_abort = 1'b0;
  assign arb__err   = 1'b0;
`endif
endmodule

// File: tb/tb_mgr_noc_locl_arb.sv
// Directed bench for mgr_noc_locl_arb: per-requester source queues and an expected-beat scoreboard.
module tb_mgr_noc_locl_arb;
  localparam int NUM_REQ  = 4;
  localparam int TYPE_W   = 2;
  localparam int PTYPE_W  = 3;
  localparam int DEST_W   = 2;
  localparam int DATA_W   = 64;
  localparam int WDOG_CYC = 16;
  localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SEOM = 2'b11;

  typedef struct packed {
    logic [1:0]  src;
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [2:0]  ptype;
    logic [1:0]  dest;
    logic        pvalid;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [2:0] owner;
  logic err;
  int n_checks = 0;
  int n_fail = 0;
  beat_t src_q [NUM_REQ][$];
  beat_t exp_q [$];
  beat_t mon_e;
  logic [NUM_REQ-1:0] xfer;

  always #5 clk = ~clk;

  mgr_noc_locl_arb_if #(.NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .PTYPE_W(PTYPE_W),
                        .DEST_W(DEST_W), .DATA_W(DATA_W)) bus ();

  mgr_noc_locl_arb #(.NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .PTYPE_W(PTYPE_W), .DEST_W(DEST_W),
                     .DATA_W(DATA_W), .WDOG_CYC(WDOG_CYC)) u_dut (
    .clk             (clk),
    .reset_poweron_n (rst_n),
    .bus             (bus),
    .arb__busy       (busy),
    .arb__owner      (owner),
    .arb__err        (err)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int s, input logic [1:0] c, input int idx, input logic [63:0] d);
    beat_t b;
    b.src    = 2'(s);
    b.cntl   = c;
    b.typ    = 2'(s + idx);
    b.ptype  = 3'(idx);
    b.dest   = 2'(3 - s);
    b.pvalid = 1'(idx);
    b.data   = d;
    return b;
  endfunction

  function automatic logic [63:0] rnd(input int s, input int idx);
    return {8'(s), 8'(idx), 16'h0, 32'($urandom())};
  endfunction

  function automatic bit pending();
    for (int r = 0; r < NUM_REQ; r++)
      if (src_q[r].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send(input beat_t b);
    src_q[b.src].push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic drive();
    beat_t b;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (src_q[r].size() != 0) begin
        b = src_q[r][0];
        bus.req__arb__valid[r]                      = 1'b1;
        bus.req__arb__cntl[2*r +: 2]                = b.cntl;
        bus.req__arb__type[TYPE_W*r +: TYPE_W]      = b.typ;
        bus.req__arb__ptype[PTYPE_W*r +: PTYPE_W]   = b.ptype;
        bus.req__arb__desttype[DEST_W*r +: DEST_W]  = b.dest;
        bus.req__arb__pvalid[r]                     = b.pvalid;
        bus.req__arb__data[DATA_W*r +: DATA_W]      = b.data;
      end else begin
        bus.req__arb__valid[r] = 1'b0;
      end
    end
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Called at the sampling point: captures this cycle's transfers, then advances past the edge.
  task automatic adv();
    xfer = bus.req__arb__valid & bus.arb__req__ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++)
      if (xfer[r] && src_q[r].size() != 0) void'(src_q[r].pop_front());
    drive();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pending() || exp_q.size() != 0) && n < 60) begin
      samp();
      adv();
      n++;
    end
    chk({tag, "_src_empty"}, 96'(pending()), 96'd0);
    chk({tag, "_exp_empty"}, 96'(exp_q.size()), 96'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.locl__noc__dp_valid === 1'b1 && bus.noc__locl__dp_ready === 1'b1) begin
      chk("noc_beat_expected", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk($sformatf("noc_beat_src%0d", mon_e.src),
            96'({bus.locl__noc__dp_cntl, bus.locl__noc__dp_type, bus.locl__noc__dp_ptype,
                 bus.locl__noc__dp_desttype, bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data}),
            96'({mon_e.cntl, mon_e.typ, mon_e.ptype, mon_e.dest, mon_e.pvalid, mon_e.data}));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.req__arb__valid    = '0;
    bus.req__arb__cntl     = '0;
    bus.req__arb__type     = '0;
    bus.req__arb__ptype    = '0;
    bus.req__arb__desttype = '0;
    bus.req__arb__pvalid   = '0;
    bus.req__arb__data     = '0;
    bus.noc__locl__dp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    samp();
    chk("rst_dp_valid", 96'(bus.locl__noc__dp_valid), 96'd0);
    chk("rst_dp_cntl",  96'(bus.locl__noc__dp_cntl), 96'd0);
    chk("rst_dp_data",  96'(bus.locl__noc__dp_data), 96'd0);
    chk("rst_ready",    96'(bus.arb__req__ready), 96'd0);
    chk("rst_busy",     96'(busy), 96'd0);
    chk("rst_owner",    96'(owner), 96'd0);
    chk("rst_err",      96'(err), 96'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    samp();
    chk("idle_dp_valid", 96'(bus.locl__noc__dp_valid), 96'd0);
    chk("idle_ready",    96'(bus.arb__req__ready), 96'd0);
    chk("idle_busy",     96'(busy), 96'd0);
    adv();

    // Two single-beat packets: req0 then req2, back to back
    send(mk(0, SEOM, 0, 64'hA5));
    send(mk(2, SEOM, 0, 64'hA5));
    drive();
    samp();
    chk("rr_c0_ready",   96'(bus.arb__req__ready), 96'h1);
    chk("rr_c0_valid",   96'(bus.locl__noc__dp_valid), 96'd0);
    adv();
    samp();
    chk("rr_c1_ready",   96'(bus.arb__req__ready), 96'h4);
    chk("rr_c1_valid",   96'(bus.locl__noc__dp_valid), 96'd1);
    adv();
    samp();
    chk("rr_c2_valid",   96'(bus.locl__noc__dp_valid), 96'd1);
    adv();

    // rr_ptr is now 3: req3 beats req1 when both are offered together
    send(mk(3, SEOM, 0, rnd(3, 0)));
    send(mk(1, SEOM, 0, rnd(1, 0)));
    drive();
    samp();
    chk("rr_ptr3_ready", 96'(bus.arb__req__ready), 96'h8);
    adv();
    samp();
    chk("rr_next_ready", 96'(bus.arb__req__ready), 96'h2);
    adv();
    drain("rr");

    // Locked 4-beat packet from req1 while req3 waits
    send(mk(1, SOM, 0, rnd(1, 0)));
    send(mk(1, MOM, 1, rnd(1, 1)));
    send(mk(1, MOM, 2, rnd(1, 2)));
    send(mk(1, EOM, 3, rnd(1, 3)));
    drive();
    samp();
    chk("lock_som_ready", 96'(bus.arb__req__ready), 96'h2);
    chk("lock_som_busy",  96'(busy), 96'd0);
    adv();
    send(mk(3, SEOM, 4, rnd(3, 4)));
    drive();
    for (int k = 1; k < 4; k++) begin
      samp();
      chk($sformatf("lock_b%0d_ready", k), 96'(bus.arb__req__ready), 96'h2);
      chk($sformatf("lock_b%0d_busy", k),  96'(busy), 96'd1);
      chk($sformatf("lock_b%0d_owner", k), 96'(owner), 96'd1);
      adv();
    end
    samp();
    chk("after_eom_ready", 96'(bus.arb__req__ready), 96'h8);
    chk("after_eom_busy",  96'(busy), 96'd0);
    adv();
    drain("lock");

    // NoC backpressure for 10 cycles during a 6-beat packet from req0
    bus.noc__locl__dp_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(mk(0, (i == 0) ? SOM : ((i == 5) ? EOM : MOM), i, rnd(0, i)));
    drive();
    for (int k = 0; k < 10; k++) begin
      samp();
      chk($sformatf("bp_c%0d_ready", k), 96'(bus.arb__req__ready), (k < 2) ? 96'h1 : 96'h0);
      if (k == 5) chk("bp_head_hold", 96'(bus.locl__noc__dp_data), 96'(exp_q[0].data));
      adv();
    end
    chk("bp_buffered", 96'(src_q[0].size()), 96'd4);
    bus.noc__locl__dp_ready = 1'b1;
    drain("bp");

    // Reset on the 3rd beat of a locked req2 packet
    for (int i = 0; i < 4; i++)
      send(mk(2, (i == 0) ? SOM : ((i == 3) ? EOM : MOM), i, rnd(2, i)));
    drive();
    samp();
    adv();
    samp();
    adv();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dp_valid", 96'(bus.locl__noc__dp_valid), 96'd0);
    chk("mid_rst_dp_data",  96'(bus.locl__noc__dp_data), 96'd0);
    chk("mid_rst_ready",    96'(bus.arb__req__ready), 96'd0);
    chk("mid_rst_busy",     96'(busy), 96'd0);
    chk("mid_rst_owner",    96'(owner), 96'd0);
    exp_q.delete();
    for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    samp();
    chk("post_rst_busy",  96'(busy), 96'd0);
    chk("post_rst_valid", 96'(bus.locl__noc__dp_valid), 96'd0);
    adv();
    send(mk(2, SEOM, 0, rnd(2, 9)));
    drive();
    samp();
    chk("restart_ready", 96'(bus.arb__req__ready), 96'h4);
    adv();
    drain("restart");

    // Owner gap inside a locked packet from req3 while req0 waits
    src_q[3].push_back(mk(3, SOM, 0, rnd(3, 0)));
    exp_q.push_back(mk(3, SOM, 0, src_q[3][0].data));
    src_q[0].push_back(mk(0, SEOM, 1, rnd(0, 1)));
    drive();
    samp();
    chk("gap_som_ready", 96'(bus.arb__req__ready), 96'h8);
    adv();
`ifdef MGR_NOC_LOCL_ARB_WATCHDOG_EN
    for (int k = 1; k <= WDOG_CYC; k++) begin
      samp();
      chk($sformatf("wdog_c%0d_busy", k),  96'(busy), 96'd1);
      chk($sformatf("wdog_c%0d_err", k),   96'(err), 96'd0);
      chk($sformatf("wdog_c%0d_ready", k), 96'(bus.arb__req__ready), 96'h8);
      adv();
    end
    samp();
    chk("wdog_err",   96'(err), 96'd1);
    chk("wdog_busy",  96'(busy), 96'd0);
    chk("wdog_ready", 96'(bus.arb__req__ready), 96'h1);
    exp_q.push_back(src_q[0][0]);
    adv();
    drain("wdog");
    samp();
    chk("wdog_err_sticky", 96'(err), 96'd1);
`else
    for (int k = 1; k <= 20; k++) begin
      samp();
      chk($sformatf("gap_c%0d_busy", k),  96'(busy), 96'd1);
      chk($sformatf("gap_c%0d_ready", k), 96'(bus.arb__req__ready), 96'h8);
      adv();
    end
    send(mk(3, EOM, 1, rnd(3, 1)));
    exp_q.push_back(src_q[0][0]);
    drive();
    samp();
    chk("gap_eom_ready", 96'(bus.arb__req__ready), 96'h8);
    adv();
    samp();
    chk("gap_next_ready", 96'(bus.arb__req__ready), 96'h1);
    adv();
    drain("gap");
    samp();
    chk("err_tied_low", 96'(err), 96'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
